// File: rtl/brightness_contrast_mc.sv
// Multi-channel brightness/contrast stage: out = clamp(round(alpha*pixel) + beta) per channel.
// Three-stage stall-able pipeline; coefficients swap at start of frame and travel with each beat.
module brightness_contrast_mc #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned COEFF_WIDTH = 16,
  parameter int unsigned FRAC_BITS   = 8,
  parameter int unsigned CHANNELS    = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              s_valid,
  output logic                              s_ready,
  input  logic [CHANNELS*DATA_WIDTH-1:0]    s_data,
  input  logic                              s_sof,
  input  logic [CHANNELS*COEFF_WIDTH-1:0]   alpha_in,
  input  logic [CHANNELS*COEFF_WIDTH-1:0]   beta_in,
  input  logic                              coeff_load,
  input  logic                              bypass,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic [CHANNELS*DATA_WIDTH-1:0]    m_data,
  output logic                              m_sof,
  output logic [CHANNELS-1:0]               m_clip
);

  localparam int unsigned PW = COEFF_WIDTH + DATA_WIDTH;
  localparam int unsigned SW = PW + 2;
  localparam logic [COEFF_WIDTH-1:0] UNITY = COEFF_WIDTH'(1 << FRAC_BITS);
  localparam logic signed [SW-1:0]   RND   = SW'((1 << FRAC_BITS) >> 1);
  localparam logic signed [SW-1:0]   MAXV  = SW'((1 << DATA_WIDTH) - 1);

  typedef logic [CHANNELS-1:0][COEFF_WIDTH-1:0] coeff_vec_t;
  typedef logic [CHANNELS-1:0][DATA_WIDTH-1:0]  pix_vec_t;
  typedef logic [CHANNELS-1:0][PW-1:0]          prod_vec_t;

  logic       w_en;
  logic       w_sof_acc;
  coeff_vec_t w_alpha_in;
  coeff_vec_t w_beta_in;
  coeff_vec_t w_alpha_use;
  coeff_vec_t w_beta_use;

  coeff_vec_t r_alpha_act;
  coeff_vec_t r_beta_act;
  coeff_vec_t r_alpha_pend;
  coeff_vec_t r_beta_pend;
  logic       r_pend;

  logic       r1_valid;
  logic       r1_sof;
  logic       r1_bypass;
  pix_vec_t   r1_data;
  coeff_vec_t r1_alpha;
  coeff_vec_t r1_beta;

  logic       r2_valid;
  logic       r2_sof;
  logic       r2_bypass;
  pix_vec_t   r2_data;
  prod_vec_t  r2_prod;
  coeff_vec_t r2_beta;
  prod_vec_t  w_prod;

  logic signed [SW-1:0] w_beta_s [CHANNELS];
  logic signed [SW-1:0] w_sum    [CHANNELS];
  logic signed [SW-1:0] w_res    [CHANNELS];
  pix_vec_t             w_out;
  logic [CHANNELS-1:0]  w_clip;

  logic                 r_m_valid;
  logic                 r_m_sof;
  pix_vec_t             r_m_data;
  logic [CHANNELS-1:0]  r_m_clip;

  assign w_en       = !r_m_valid || m_ready;
  assign s_ready    = w_en;
  assign w_sof_acc  = s_valid && w_en && s_sof;
  assign w_alpha_in = alpha_in;
  assign w_beta_in  = beta_in;

  // Coefficients a beat entering now would use, including a swap on its own sof.
  always_comb begin
    w_alpha_use = r_alpha_act;
    w_beta_use  = r_beta_act;
    if (s_sof) begin
      if (coeff_load) begin
        w_alpha_use = w_alpha_in;
        w_beta_use  = w_beta_in;
      end else if (r_pend) begin
        w_alpha_use = r_alpha_pend;
        w_beta_use  = r_beta_pend;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_alpha_act  <= {CHANNELS{UNITY}};
      r_beta_act   <= '0;
      r_alpha_pend <= '0;
      r_beta_pend  <= '0;
      r_pend       <= 1'b0;
    end else if (w_sof_acc) begin
      r_alpha_act <= w_alpha_use;
      r_beta_act  <= w_beta_use;
      r_pend      <= 1'b0;
    end else if (coeff_load) begin
      r_alpha_pend <= w_alpha_in;
      r_beta_pend  <= w_beta_in;
      r_pend       <= 1'b1;
    end
  end

  // Stage 1: capture the beat together with the coefficients it was accepted with.
  always_ff @(posedge clk) begin
    if (rst) begin
      r1_valid  <= 1'b0;
      r1_sof    <= 1'b0;
      r1_bypass <= 1'b0;
      r1_data   <= '0;
      r1_alpha  <= '0;
      r1_beta   <= '0;
    end else if (w_en) begin
      r1_valid  <= s_valid;
      r1_sof    <= s_sof;
      r1_bypass <= bypass;
      r1_data   <= s_data;
      r1_alpha  <= w_alpha_use;
      r1_beta   <= w_beta_use;
    end
  end

  always_comb begin
    w_prod = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      w_prod[c] = PW'(r1_alpha[c]) * PW'(r1_data[c]);
    end
  end

  // Stage 2: unsigned gain product.
  always_ff @(posedge clk) begin
    if (rst) begin
      r2_valid  <= 1'b0;
      r2_sof    <= 1'b0;
      r2_bypass <= 1'b0;
      r2_data   <= '0;
      r2_prod   <= '0;
      r2_beta   <= '0;
    end else if (w_en) begin
      r2_valid  <= r1_valid;
      r2_sof    <= r1_sof;
      r2_bypass <= r1_bypass;
      r2_data   <= r1_data;
      r2_prod   <= w_prod;
      r2_beta   <= r1_beta;
    end
  end

  // Offset, round-half-up, arithmetic shift back to pixel units, then clamp.
  always_comb begin
    w_out  = '0;
    w_clip = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      w_beta_s[c] = SW'($signed(r2_beta[c]));
      w_sum[c]    = $signed({2'b00, r2_prod[c]}) + (w_beta_s[c] <<< FRAC_BITS) + RND;
      w_res[c]    = w_sum[c] >>> FRAC_BITS;
      if (r2_bypass) begin
        w_out[c] = r2_data[c];
      end else if (w_res[c][SW-1]) begin
        w_out[c]  = '0;
        w_clip[c] = 1'b1;
      end else if (w_res[c] > MAXV) begin
        w_out[c]  = '1;
        w_clip[c] = 1'b1;
      end else begin
        w_out[c] = w_res[c][DATA_WIDTH-1:0];
      end
    end
  end

  // Stage 3: output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_m_valid <= 1'b0;
      r_m_sof   <= 1'b0;
      r_m_data  <= '0;
      r_m_clip  <= '0;
    end else if (w_en) begin
      r_m_valid <= r2_valid;
      r_m_sof   <= r2_sof;
      r_m_data  <= w_out;
      r_m_clip  <= w_clip;
    end
  end

  assign m_valid = r_m_valid;
  assign m_sof   = r_m_sof;
  assign m_data  = r_m_data;
  assign m_clip  = r_m_clip;

endmodule

// File: tb/tb_brightness_contrast_mc.sv
// Directed bench for brightness_contrast_mc: hand-computed vectors, backpressure and reset cases.
module tb_brightness_contrast_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [23:0] s_data;
  logic        s_sof;
  logic [47:0] alpha_in;
  logic [47:0] beta_in;
  logic        coeff_load;
  logic        bypass;
  logic        m_valid;
  logic        m_ready;
  logic [23:0] m_data;
  logic        m_sof;
  logic [2:0]  m_clip;

  typedef struct packed {
    logic [23:0] data;
    logic [2:0]  clip;
    logic        sof;
  } beat_t;

  beat_t q[$];
  int    n_pass  = 0;
  int    n_total = 0;
  bit    stream_done;

  brightness_contrast_mc #(
    .DATA_WIDTH(8), .COEFF_WIDTH(16), .FRAC_BITS(8), .CHANNELS(3)
  ) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_sof(s_sof), .alpha_in(alpha_in), .beta_in(beta_in), .coeff_load(coeff_load),
    .bypass(bypass), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_sof(m_sof), .m_clip(m_clip)
  );

  always #5 clk = ~clk;

  // Collect transferred output beats mid-cycle.
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) q.push_back({m_data, m_clip, m_sof});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [23:0] rep(input logic [7:0] x);
    return {x, x, x};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [23:0] d, input logic sof);
    int waited = 0;
    s_data  = d;
    s_sof   = sof;
    s_valid = 1'b1;
    @(negedge clk);
    while (!s_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!s_ready) check("send_accept", 32'(s_ready), 32'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_sof   = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [23:0] d, input logic [2:0] clip,
                            input logic sof);
    int    waited = 0;
    beat_t b;
    while (q.size() == 0 && waited < 100) begin
      tick();
      waited++;
    end
    if (q.size() == 0) begin
      check({tag, "_present"}, 32'(q.size()), 32'd1);
      return;
    end
    b = q.pop_front();
    check({tag, "_data"}, 32'(b.data), 32'(d));
    check({tag, "_clip"}, 32'(b.clip), 32'(clip));
    check({tag, "_sof"},  32'(b.sof),  32'(sof));
  endtask

  task automatic load(input logic [47:0] a, input logic [47:0] b);
    alpha_in   = a;
    beta_in    = b;
    coeff_load = 1'b1;
    tick();
    coeff_load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_sof = 1'b0; s_data = '0; alpha_in = '0; beta_in = '0;
    coeff_load = 1'b0; bypass = 1'b0; m_ready = 1'b0; stream_done = 1'b0;
    repeat (3) tick();
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data",  32'(m_data),  32'd0);
    check("rst_m_clip",  32'(m_clip),  32'd0);
    check("rst_m_sof",   32'(m_sof),   32'd0);
    rst = 1'b0;
    check("rst_s_ready", 32'(s_ready), 32'd1);
    m_ready = 1'b1;

    // Unity path and three-cycle latency.
    send(rep(8'd0), 1'b0);
    check("lat_1", 32'(m_valid), 32'd0);
    tick();
    check("lat_2", 32'(m_valid), 32'd0);
    tick();
    check("lat_3", 32'(m_valid), 32'd1);
    expect_out("unity_0", rep(8'd0), 3'b000, 1'b0);
    send(rep(8'd100), 1'b0);
    send(rep(8'd255), 1'b0);
    expect_out("unity_100", rep(8'd100), 3'b000, 1'b0);
    expect_out("unity_255", rep(8'd255), 3'b000, 1'b0);

    // Gain 1.5.
    load({3{16'h0180}}, 48'd0);
    send(rep(8'd100), 1'b1);
    send(rep(8'd200), 1'b0);
    expect_out("gain_100", rep(8'd150), 3'b000, 1'b1);
    expect_out("gain_200", rep(8'd255), 3'b111, 1'b0);

    // Negative offset.
    load({3{16'h0100}}, {3{16'hFFCE}});
    send(rep(8'd30), 1'b1);
    send(rep(8'd80), 1'b0);
    expect_out("beta_30", rep(8'd0),  3'b111, 1'b1);
    expect_out("beta_80", rep(8'd30), 3'b000, 1'b0);

    // Round half up with gain 0.5.
    load({3{16'h0080}}, 48'd0);
    send(rep(8'd3), 1'b1);
    send(rep(8'd2), 1'b0);
    expect_out("round_3", rep(8'd2), 3'b000, 1'b1);
    expect_out("round_2", rep(8'd1), 3'b000, 1'b0);

    // Per-channel gains 2.0 / 1.0 / 0.5, then bypass versus processed.
    load({16'h0080, 16'h0100, 16'h0200}, 48'd0);
    send(rep(8'd60), 1'b1);
    expect_out("perch_60", {8'd30, 8'd60, 8'd120}, 3'b000, 1'b1);
    bypass = 1'b1;
    send({8'd250, 8'd200, 8'd200}, 1'b0);
    bypass = 1'b0;
    send({8'd250, 8'd200, 8'd200}, 1'b0);
    expect_out("bypass", {8'd250, 8'd200, 8'd200}, 3'b000, 1'b0);
    expect_out("perch_clip", {8'd125, 8'd200, 8'd255}, 3'b001, 1'b0);

    // Mid-frame load takes effect only at the next sof.
    load({3{16'h0100}}, 48'd0);
    send(rep(8'd10), 1'b1);
    expect_out("mid_unity", rep(8'd10), 3'b000, 1'b1);
    load({3{16'h0200}}, 48'd0);
    send(rep(8'd10), 1'b0);
    send(rep(8'd10), 1'b1);
    send(rep(8'd10), 1'b0);
    expect_out("mid_before_sof", rep(8'd10), 3'b000, 1'b0);
    expect_out("mid_sof",        rep(8'd20), 3'b000, 1'b1);
    expect_out("mid_after_sof",  rep(8'd20), 3'b000, 1'b0);

    // Load coincident with sof applies to that beat and leaves nothing pending.
    alpha_in = {3{16'h0300}};
    beta_in  = 48'd0;
    coeff_load = 1'b1;
    send(rep(8'd10), 1'b1);
    coeff_load = 1'b0;
    send(rep(8'd10), 1'b0);
    send(rep(8'd10), 1'b1);
    expect_out("coinc_sof",   rep(8'd30), 3'b000, 1'b1);
    expect_out("coinc_next",  rep(8'd30), 3'b000, 1'b0);
    expect_out("coinc_nopend", rep(8'd30), 3'b000, 1'b1);

    // Later load overwrites an earlier pending one.
    load({3{16'h0400}}, 48'd0);
    load({3{16'h0100}}, 48'd0);
    send(rep(8'd10), 1'b1);
    expect_out("overwrite", rep(8'd10), 3'b000, 1'b1);

    // Stall: output holds, input not ready.
    m_ready = 1'b0;
    send(rep(8'd11), 1'b0);
    send(rep(8'd22), 1'b0);
    send(rep(8'd33), 1'b0);
    check("stall_valid", 32'(m_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("stall_data",  32'(m_data),  32'(rep(8'd11)));
      check("stall_ready", 32'(s_ready), 32'd0);
    end
    m_ready = 1'b1;
    expect_out("stall_b0", rep(8'd11), 3'b000, 1'b0);
    expect_out("stall_b1", rep(8'd22), 3'b000, 1'b0);
    expect_out("stall_b2", rep(8'd33), 3'b000, 1'b0);

    // Twenty beats against random downstream readiness.
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          send({8'(i * 7 + 3), 8'(i * 7 + 2), 8'(i * 7 + 1)}, 1'b0);
        end
        stream_done = 1'b1;
      end
      begin
        while (!stream_done) begin
          tick();
          m_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    m_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      expect_out("rand", {8'(i * 7 + 3), 8'(i * 7 + 2), 8'(i * 7 + 1)}, 3'b000, 1'b0);
    end
    repeat (5) tick();
    check("rand_no_extra", 32'(q.size()), 32'd0);

    // Reset with beats in flight clears pipeline and coefficients.
    load({3{16'h0200}}, 48'd0);
    send(rep(8'd10), 1'b1);
    expect_out("prerst", rep(8'd20), 3'b000, 1'b1);
    load({3{16'h0300}}, 48'd0);
    send(rep(8'd1), 1'b0);
    send(rep(8'd2), 1'b0);
    send(rep(8'd3), 1'b0);
    rst = 1'b1;
    tick();
    check("rst_flight_valid", 32'(m_valid), 32'd0);
    rst = 1'b0;
    q.delete();
    send(rep(8'd77), 1'b1);
    expect_out("post_rst", rep(8'd77), 3'b000, 1'b1);
    repeat (5) tick();
    check("post_rst_no_extra", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
